d_trig: RTL and testbench

// - Parameterised D-type register bank: samples bus d on each rising clk edge and

---
 rtl/d_trig.sv | 41 ++++
 tb/tb_d_trig.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/d_trig.sv
// Parameterised D-type register bank: d is captured on every rising clk edge
// and reaches q after STAGES register stages. Active-low asynchronous reset.
module d_trig #(
  parameter int               WIDTH       = 4,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
    $error("d_trig: WIDTH and STAGES must both be >= 1");
  end

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage[0] <= RESET_VALUE;
    end else begin
      r_stage[0] <= d;
    end
  end

  // Each later stage copies its predecessor; every stage resets independently.
  for (genvar i = 1; i < STAGES; i++) begin : g_stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stage[i] <= RESET_VALUE;
      end else begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: tb/tb_d_trig.sv
// Self-checking bench for d_trig: a 4-bit single-stage instance and an 8-bit
// three-stage instance, compared against a sample-history reference model.
module tb_d_trig;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [7:0] d8;
  logic [7:0] q8;

  int vectors     = 0;
  int miscompares = 0;

  // Every value sampled since the last reset, oldest first.
  logic [7:0] hist4 [$];
  logic [7:0] hist8 [$];

  always #5 clk = ~clk;

  d_trig u_dut4 (
    .clk (clk),
    .rst (rst),
    .d   (d4),
    .q   (q4)
  );

  d_trig #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (8'h5A)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .d   (d8),
    .q   (q8)
  );

  // q shows the sample taken STAGES-1 edges ago, or the reset value until enough samples exist.
  function automatic logic [7:0] expect4();
    if (hist4.size() >= 1) return hist4[hist4.size()-1];
    return 8'h00;
  endfunction

  function automatic logic [7:0] expect8();
    if (hist8.size() >= 3) return hist8[hist8.size()-3];
    return 8'h5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBoth(input string tag);
    checkOutput({tag, "/q4"}, {4'h0, q4}, expect4());
    checkOutput({tag, "/q8"}, q8, expect8());
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] v4, input logic [7:0] v8);
    d4 = v4;
    d8 = v8;
    @(posedge clk);
    if (rst) begin
      hist4.push_back({4'h0, d4});
      hist8.push_back(d8);
    end
    #3;
    checkBoth(tag);
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    hist4.delete();
    hist8.delete();
    #1;
    checkBoth("async_reset");
    rst = 1'b1;
    #1;
    checkBoth("reset_release");
  endtask

  initial begin
    logic [3:0] hold4;
    logic [7:0] hold8;

    rst = 1'b0;
    d4  = 'x;
    d8  = 'x;
    repeat (10) begin
      #100;
      checkBoth("reset_hold");
    end

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkBoth("release_no_change");

    applyStimulus("seq1", 4'h1, 8'h11);
    applyStimulus("seq2", 4'h2, 8'h22);
    applyStimulus("seq3", 4'h3, 8'h33);
    applyStimulus("seq4", 4'h4, 8'h44);
    repeat (3) applyStimulus("hold4", 4'h4, 8'h44);

    applyStimulus("load3", 4'h3, 8'h77);
    pulseReset();
    applyStimulus("refill", 4'h5, 8'h12);

    // Glitch on d between edges; only the value present at the edge counts.
    d4 = 4'h5;
    d8 = 8'h34;
    #1 d4 = 4'hA;
    d8 = 8'hCB;
    #1 d4 = 4'h5;
    d8 = 8'h34;
    applyStimulus("glitch", 4'h5, 8'h34);
    applyStimulus("glitch_next", 4'h6, 8'h56);

    @(posedge clk);
    rst = 1'b0;
    hist4.delete();
    hist8.delete();
    #1;
    checkBoth("reset_at_edge");
    #1 rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", 4'($urandom), 8'($urandom));
      if ($urandom_range(0, 19) == 0) pulseReset();
    end

    hold4 = 4'($urandom);
    hold8 = 8'($urandom);
    repeat (1010) applyStimulus("steady", hold4, hold8);
    checkOutput("steady_final/q4", {4'h0, q4}, {4'h0, hold4});
    checkOutput("steady_final/q8", q8, hold8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
